// File: rtl/fifo_serializer.sv
// fifo_serializer: pops DATA_WIDTH words from an upstream FIFO and emits them
// as RATIO = DATA_WIDTH/SYMBOL_WIDTH symbols over a valid/ready stream.
//
// Ports:
//   clock           - single clock, rising edge
//   rst             - synchronous active-high reset
//   data_in         - word from upstream FIFO (sampled only while data_in_valid)
//   data_in_valid   - upstream word available
//   data_in_ack     - pop strobe (combinational); word moves when valid & ack
//   data_out        - current symbol (registered)
//   data_out_valid  - data_out holds a valid symbol (registered)
//   data_out_ready  - downstream accepts; symbol moves when valid & ready
//   data_out_last   - final symbol of the current word (registered)
module fifo_serializer #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned SYMBOL_WIDTH = 8,
    parameter int unsigned MSB_FIRST    = 1
) (
    input  logic                    clock,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic                    data_in_valid,
    output logic                    data_in_ack,
    output logic [SYMBOL_WIDTH-1:0] data_out,
    output logic                    data_out_valid,
    input  logic                    data_out_ready,
    output logic                    data_out_last
);

    localparam int unsigned RATIO    = DATA_WIDTH / SYMBOL_WIDTH;
    localparam int unsigned CNT_W    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(RATIO - 1);

    // Word must split into a whole number (>= 2) of symbols.
    generate
        if (((DATA_WIDTH % SYMBOL_WIDTH) != 0) || (RATIO < 2)) begin : g_bad_ratio
            $error("fifo_serializer: DATA_WIDTH must be RATIO*SYMBOL_WIDTH with RATIO >= 2");
        end
    endgenerate

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   word_q, word_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [SYMBOL_WIDTH-1:0] out_d;
    logic                    valid_d;
    logic                    last_d;
    logic                    last_xfer;
    logic                    load;

    // Symbol number idx of word w in emission order.
    function automatic logic [SYMBOL_WIDTH-1:0] symbol_at(
        input logic [DATA_WIDTH-1:0] w,
        input logic [CNT_W-1:0]      idx
    );
        int unsigned pos;
        pos = (MSB_FIRST != 0) ? (RATIO - 1 - 32'(idx)) : 32'(idx);
        return SYMBOL_WIDTH'(w >> (pos * SYMBOL_WIDTH));
    endfunction

    // State and output registers.
    always_ff @(posedge clock) begin
        if (rst) begin
            state_q        <= IDLE;
            word_q         <= '0;
            cnt_q          <= '0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
            data_out_last  <= 1'b0;
        end else begin
            state_q        <= state_d;
            word_q         <= word_d;
            cnt_q          <= cnt_d;
            data_out       <= out_d;
            data_out_valid <= valid_d;
            data_out_last  <= last_d;
        end
    end

    // Next-state, pop strobe and next output values.
    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        cnt_d     = cnt_q;
        out_d     = data_out;
        valid_d   = data_out_valid;
        last_d    = data_out_last;

        last_xfer   = (state_q == SHIFT) && data_out_ready && (cnt_q == LAST_IDX);
        // Ack does not look at data_in_valid; the pop is the valid&ack product.
        data_in_ack = !rst && ((state_q == IDLE) || last_xfer);
        load        = data_in_valid && data_in_ack;

        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
            SHIFT: begin
                if (data_out_ready) begin
                    if (cnt_q == LAST_IDX) begin
                        // Overridden below when the next word is ready.
                        state_d = IDLE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                    end else begin
                        cnt_d  = cnt_q + CNT_W'(1);
                        out_d  = symbol_at(word_q, cnt_q + CNT_W'(1));
                        last_d = ((cnt_q + CNT_W'(1)) == LAST_IDX);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            state_d = SHIFT;
            word_d  = data_in;
            cnt_d   = '0;
            out_d   = symbol_at(data_in, '0);
            valid_d = 1'b1;
            last_d  = 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_serializer.sv
// Scoreboard bench for fifo_serializer: one MSB-first and one LSB-first
// instance share the same stimulus; every pop pushes the expected symbol
// sequence, and a negedge monitor pops and compares each presented symbol.
module tb_fifo_serializer;

    localparam int unsigned DW = 32;
    localparam int unsigned SW = 8;
    localparam int unsigned R  = DW / SW;

    logic          clock = 1'b0;
    logic          rst;
    logic [DW-1:0] data_in;
    logic          data_in_valid;
    logic          data_out_ready;
    logic          ack    [2];
    logic [SW-1:0] dout   [2];
    logic          dvalid [2];
    logic          dlast  [2];

    logic [SW-1:0] exp_q [2][$];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            pop_cnt  = 0;
    int            words_sent = 0;
    bit            prev_rst = 1'b0;

    always #5 clock = ~clock;

    fifo_serializer #(.DATA_WIDTH(DW), .SYMBOL_WIDTH(SW), .MSB_FIRST(1)) u_msb (
        .clock(clock), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
        .data_in_ack(ack[0]), .data_out(dout[0]), .data_out_valid(dvalid[0]),
        .data_out_ready(data_out_ready), .data_out_last(dlast[0])
    );

    fifo_serializer #(.DATA_WIDTH(DW), .SYMBOL_WIDTH(SW), .MSB_FIRST(0)) u_lsb (
        .clock(clock), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
        .data_in_ack(ack[1]), .data_out(dout[1]), .data_out_valid(dvalid[1]),
        .data_out_ready(data_out_ready), .data_out_last(dlast[1])
    );

    task automatic check(input string name, input int k, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d @%0t: got %0h, expected %0h", name, k, $time, act, exp);
        end
    endtask

    // Monitor / scoreboard: sampled mid-cycle, describes the upcoming edge.
    always @(negedge clock) begin
        for (int k = 0; k < 2; k++) begin
            if (prev_rst) begin
                check("rst_dout", k, 32'(dout[k]), 32'h0);
                check("rst_last", k, 32'(dlast[k]), 32'h0);
            end
            if (rst) begin
                check("ack_in_rst", k, 32'(ack[k]), 32'h0);
                exp_q[k].delete();
            end else begin
                int sz;
                sz = exp_q[k].size();
                check("valid", k, 32'(dvalid[k]), 32'(sz != 0));
                check("ack", k, 32'(ack[k]), 32'((sz == 0) || (data_out_ready && sz == 1)));
                if (dvalid[k] && sz != 0) begin
                    check("data", k, 32'(dout[k]), 32'(exp_q[k][0]));
                    check("last", k, 32'(dlast[k]), 32'(sz == 1));
                    if (data_out_ready) void'(exp_q[k].pop_front());
                end
                if (data_in_valid && ack[k]) begin
                    if (k == 0) pop_cnt++;
                    for (int i = 0; i < int'(R); i++) begin
                        if (k == 0) exp_q[k].push_back(SW'(data_in >> (SW * (R - 1 - i))));
                        else        exp_q[k].push_back(SW'(data_in >> (SW * i)));
                    end
                end
            end
        end
        prev_rst = rst;
    end

    // Present one word until it is popped; returns 1 ns after the pop edge.
    task automatic send_word(input logic [DW-1:0] w);
        bit popped;
        popped = 1'b0;
        data_in       = w;
        data_in_valid = 1'b1;
        for (int c = 0; c < 200 && !popped; c++) begin
            @(negedge clock);
            popped = ack[0];
            @(posedge clock);
            #1;
        end
        check("pop_timeout", 0, 32'(popped), 32'h1);
        if (popped) words_sent++;
        data_in_valid = 1'b0;
        data_in       = $urandom;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
            data_in = $urandom;
        end
    endtask

    initial begin
        bit have;
        bit popped;
        int issued;
        rst            = 1'b1;
        data_in        = '0;
        data_in_valid  = 1'b0;
        data_out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        rst = 1'b0;
        idle_cycles(3);

        // Single word, then upstream starved.
        send_word(32'hA1B2C3D4);
        idle_cycles(8);

        // Back-to-back words with continuous valid.
        send_word(32'h00010203);
        send_word(32'h04050607);
        send_word(32'h08090A0B);
        idle_cycles(8);

        // Backpressure while the second symbol is presented.
        send_word(32'hA1B2C3D4);
        @(posedge clock);
        #1;
        data_out_ready = 1'b0;
        idle_cycles(5);
        data_out_ready = 1'b1;
        idle_cycles(8);

        // Reset after the second symbol transfers.
        send_word(32'hA1B2C3D4);
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        rst = 1'b1;
        @(posedge clock);
        #1;
        rst = 1'b0;
        idle_cycles(2);
        send_word(32'h11223344);
        idle_cycles(8);

        // Randomised upstream gaps and downstream backpressure.
        have   = 1'b0;
        issued = 0;
        for (int c = 0; c < 20000 && (issued < 300 || have); c++) begin
            @(negedge clock);
            popped = data_in_valid && ack[0];
            @(posedge clock);
            #1;
            if (popped) begin
                words_sent++;
                have = 1'b0;
            end
            if (!have && issued < 300 && $urandom_range(0, 2) != 0) begin
                data_in = $urandom;
                have    = 1'b1;
                issued++;
            end else if (!have) begin
                data_in = $urandom;
            end
            data_in_valid  = have;
            data_out_ready = ($urandom_range(0, 3) != 0);
        end
        check("rand_words_done", 0, 32'(have), 32'h0);

        // Drain.
        data_in_valid  = 1'b0;
        data_out_ready = 1'b1;
        for (int c = 0; c < 50 && (exp_q[0].size() != 0 || exp_q[1].size() != 0); c++)
            idle_cycles(1);
        idle_cycles(2);
        check("drain0", 0, 32'(exp_q[0].size()), 32'h0);
        check("drain1", 1, 32'(exp_q[1].size()), 32'h0);
        check("pop_count", 0, 32'(pop_cnt), 32'(words_sent));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_serializer.md
FIFO_SERIALIZER -- requirements
Module: fifo_serializer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning the input word width (the FIFO read-side word).
REQ-002 The block SHALL have parameter SYMBOL_WIDTH, default 8, meaning the output symbol width.
REQ-003 The block SHALL have parameter MSB_FIRST, default 1, meaning 1 = emit the most-significant symbol first, 0 = emit the least-significant symbol first.
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port data_in, input, DATA_WIDTH bits: word from the upstream FIFO, sampled only while data_in_valid=1.
REQ-007 The block SHALL have port data_in_valid, input, 1 bit: upstream word available.
REQ-008 The block SHALL have port data_in_ack, output, 1 bit: pop strobe; a word transfers on any cycle with data_in_valid=1 and data_in_ack=1.
REQ-009 The block SHALL have port data_out, output, SYMBOL_WIDTH bits: current symbol.
REQ-010 The block SHALL have port data_out_valid, output, 1 bit: data_out holds a valid symbol.
REQ-011 The block SHALL have port data_out_ready, input, 1 bit: downstream accepts; a symbol transfers on any cycle with data_out_valid=1 and data_out_ready=1.
REQ-012 The block SHALL have port data_out_last, output, 1 bit: high with the final symbol of each word.

Function
REQ-013 The design SHALL support DATA_WIDTH equal to RATIO*SYMBOL_WIDTH with RATIO >= 2; any other combination SHALL be rejected at elaboration.
REQ-014 The block SHALL be a two-state FSM: IDLE (no word held) and SHIFT (a word is held and its symbols are being emitted).
REQ-015 data_in_ack SHALL be combinational: 1 in IDLE; in SHIFT, 1 only when the last symbol transfers in that same cycle; 0 whenever rst=1.
REQ-016 data_in_ack SHALL depend on data_in_valid only through the transfer condition; the block SHALL NOT pop when data_in_valid=0.
REQ-017 On a word transfer, the word SHALL load into a shift register, the symbol counter SHALL reset to 0, and data_out_valid SHALL be 1 on the next cycle with the first symbol on data_out.
REQ-018 Latency SHALL be exactly one cycle, from the word-transfer edge to the first symbol valid.
REQ-019 Symbol order: with MSB_FIRST=1, the first symbol SHALL be bits [DATA_WIDTH-1 -: SYMBOL_WIDTH], then descending; with MSB_FIRST=0, the first symbol SHALL be bits [SYMBOL_WIDTH-1:0], then ascending.
REQ-020 On each symbol transfer that is not the last, the counter SHALL increment by 1 and the next symbol SHALL appear on the following cycle.
REQ-021 While data_out_valid=1 and data_out_ready=0, data_out, data_out_last, the counter and the held word SHALL remain stable.
REQ-022 The counter SHALL be clog2(RATIO) bits wide; data_out_last SHALL be 1 exactly when the counter equals RATIO-1 and data_out_valid=1.
REQ-023 When the last symbol transfers and data_in_valid=1, the next word SHALL load on the same edge, staying in SHIFT with no idle cycle (sustained 1 symbol/cycle).
REQ-024 When the last symbol transfers and data_in_valid=0, the FSM SHALL go to IDLE and data_out_valid SHALL be 0 on the next cycle.
REQ-025 data_in changes while data_in_ack=0 SHALL have no effect on the held word.
REQ-026 data_out, data_out_valid and data_out_last SHALL be registered outputs; there SHALL be no combinational path from data_out_ready to data_out.

Reset
REQ-027 While rst=1 at a rising edge, the FSM SHALL enter IDLE and the counter SHALL be set to 0.
REQ-028 While rst=1 at a rising edge, data_out SHALL be set to 0, data_out_valid to 0 and data_out_last to 0.
REQ-029 A reset asserted mid-word SHALL discard the partial word, with no further symbols emitted and no extra pop.
REQ-030 In the first cycle after rst deasserts, the block SHALL be in IDLE with data_in_ack=1.

Verification
REQ-031 Single word: MSB_FIRST=1, data_in=0xA1B2C3D4 valid for 1 cycle, ready=1 -> symbols 0xA1,0xB2,0xC3,0xD4 on 4 consecutive cycles starting 1 cycle after the pop; last=1 only on 0xD4; valid=0 after.
REQ-032 LSB order: MSB_FIRST=0, the same word -> 0xD4,0xC3,0xB2,0xA1; last=1 only on 0xA1.
REQ-033 Back-to-back: 3 words 0x00010203, 0x04050607, 0x08090A0B continuously valid, ready=1 -> 12 symbols 0x00..0x0B on 12 consecutive cycles; data_in_ack pulses on the cycles of symbols 0x03 and 0x07 plus the initial load.
REQ-034 Backpressure: ready=0 for 5 cycles while 0xB2 is presented -> data_out stays 0xB2, valid=1, ack=0 throughout; the sequence resumes correctly.
REQ-035 Reset mid-word: rst=1 for 1 cycle after 0xB2 transfers -> next cycle valid=0, data_out=0, last=0; a following word 0x11223344 emits 0x11 first.
REQ-036 Upstream starved: data_in_valid=0 after one word -> exactly one ack pulse; valid drops the cycle after 0xD4 transfers; no pop while data_in_valid=0.
